// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation controller: register map, FSM states,
// watchdog fail code and a saturating counter helper.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [3:0] ADDR_TOHOST = 4'h0;
    localparam logic [3:0] ADDR_PUTC   = 4'h4;
    localparam logic [3:0] ADDR_CYCLE  = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'hC;

    localparam logic [30:0] TIMEOUT_FAIL_CODE = 31'h7FFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sim_ctrl_fifo.sv
// Console character FIFO: 8-bit entries, power-of-two depth, occupancy output.
// Head data reads as zero while empty so the byte stream is never undefined.
module sim_ctrl_fifo
    import sim_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [7:0]               i_wdata,
    input  logic                     i_pop,
    output logic [7:0]               o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = o_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sim_ctrl.sv
// Simulation controller: TOHOST/PUTC/CYCLE/STATUS registers, console FIFO, halt FSM.
// Optional watchdog enabled by defining SIM_CTRL_TIMEOUT_EN.
module sim_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_data,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic [31:0] cycle_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        r_state;
    state_e        w_state_nxt;
    logic          r_pass;
    logic          w_pass_nxt;
    logic [30:0]   r_fail;
    logic [30:0]   w_fail_nxt;
    logic          r_done;
    logic [31:0]   r_cycle;
    logic [31:0]   r_tohost;
    logic          r_resp_valid;
    logic [31:0]   r_resp_rdata;

    logic          w_accept;
    logic          w_wr;
    logic          w_rd;
    logic          w_tohost_wr;
    logic          w_putc_wr;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic [CW-1:0] w_count;
    logic [31:0]   w_rdata;

    assign w_putc_wr   = req_we && (req_addr == ADDR_PUTC);
    assign req_ready   = !(req_valid && w_putc_wr && w_full);
    assign w_accept    = req_valid && req_ready;
    assign w_wr        = w_accept && req_we;
    assign w_rd        = w_accept && !req_we;
    assign w_tohost_wr = w_wr && (req_addr == ADDR_TOHOST);
    assign w_push      = w_accept && w_putc_wr && (r_state != ST_HALTED);
    assign w_pop       = char_valid && char_ready;
    assign char_valid  = !w_empty;

    sim_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_wdata (req_wdata[7:0]),
        .i_pop   (w_pop),
        .o_rdata (char_data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pass_nxt  = r_pass;
        w_fail_nxt  = r_fail;
        unique case (r_state)
            ST_RUN: begin
                if (w_tohost_wr && req_wdata[0]) begin
                    w_pass_nxt  = (req_wdata == 32'd1);
                    w_fail_nxt  = req_wdata[31:1];
                    w_state_nxt = ST_DRAIN;
                end
`ifdef SIM_CTRL_TIMEOUT_EN
                if (r_cycle >= 32'(TIMEOUT_CYCLES)) begin
                    w_pass_nxt  = 1'b0;
                    w_fail_nxt  = TIMEOUT_FAIL_CODE;
                    w_state_nxt = ST_DRAIN;
                end
`endif
            end
            ST_DRAIN: begin
                if (w_empty && !w_push) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

`ifndef SIM_CTRL_TIMEOUT_EN
    logic w_unused_timeout;
    assign w_unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        w_rdata = '0;
        case (req_addr)
            ADDR_TOHOST: w_rdata = r_tohost;
            ADDR_CYCLE:  w_rdata = r_cycle;
            ADDR_STATUS: w_rdata = {16'(w_count), 14'b0, r_pass, r_done};
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_pass  <= 1'b0;
            r_fail  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pass  <= w_pass_nxt;
            r_fail  <= w_fail_nxt;
            r_done  <= (w_state_nxt == ST_HALTED);
        end
    end

    // Counter freezes once halted so the final value is the test's run length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle      <= '0;
            r_tohost     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            if (r_state != ST_HALTED) begin
                r_cycle <= sat_inc(r_cycle);
            end
            if (w_tohost_wr) begin
                r_tohost <= req_wdata;
            end
            r_resp_valid <= w_rd;
            r_resp_rdata <= w_rd ? w_rdata : 32'd0;
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_code   = r_fail;
    assign cycle_count = r_cycle;

endmodule

// File: doc/sim_ctrl.md
SIM_CTRL -- requirements
Module: sim_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, character FIFO entries (power of two, >=2).
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, watchdog limit (used only under SIM_CTRL_TIMEOUT_EN).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 req_valid  in  1  core bus request present.
REQ-006 req_ready  out  1  request accepted this cycle when high together with req_valid.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  4  byte offset: 0x0 TOHOST, 0x4 PUTC, 0x8 CYCLE, 0xC STATUS.
REQ-009 req_wdata  in  32  write data.
REQ-010 resp_valid  out  1  read data valid.
REQ-011 resp_rdata  out  32  read data.
REQ-012 char_valid / char_ready / char_data  out / in / 8  console byte stream toward the bench.
REQ-013 done  out  1  simulation finished; pass  out  1  result; fail_code  out  31  failing test number.
REQ-014 cycle_count  out  32  cycles since reset release.

Function
REQ-015 States RUN, DRAIN, HALTED; reset enters RUN.
REQ-016 Handshake: transfer when req_valid && req_ready; req_ready is low only for a PUTC write while the FIFO is full, high otherwise.
REQ-017 TOHOST write in RUN with wdata[0]=1: pass <= (wdata==1), fail_code <= wdata[31:1], go DRAIN; TOHOST write with wdata[0]=0 is ignored.
REQ-018 PUTC write pushes wdata[7:0]; accepted in RUN and DRAIN, silently dropped in HALTED.
REQ-019 FIFO: char_valid = not empty, char_data = head; pop on char_valid && char_ready; simultaneous push and pop when full is not accepted (req_ready low), when empty push then pop next cycle (no bypass).
REQ-020 DRAIN -> HALTED in the first cycle the FIFO is empty and no push is accepted.
REQ-021 done = (state == HALTED), registered; pass/fail_code hold until reset.
REQ-022 cycle_count increments by 1 each cycle in RUN and DRAIN, freezes in HALTED, saturates at 0xFFFFFFFF.
REQ-023 Reads: resp_valid pulses exactly one cycle after acceptance; CYCLE returns cycle_count, STATUS returns {fifo_count in [31:16], 14'b0, pass, done}, TOHOST returns last accepted TOHOST value, PUTC returns 0.
REQ-024 resp_rdata is 0 whenever resp_valid is low.
REQ-025 Writes to CYCLE/STATUS and undefined offsets are accepted and ignored.

Reset
REQ-026 Asserting rst at any time, including mid-DRAIN, returns all outputs to reset values within the same clock-independent interval.
REQ-027 Reset values: req_ready=1, resp_valid=0, resp_rdata=0, char_valid=0, char_data=0, done=0, pass=0, fail_code=0, cycle_count=0, FIFO empty.

Configuration
REQ-028 Macro SIM_CTRL_TIMEOUT_EN: when defined, cycle_count reaching TIMEOUT_CYCLES in RUN forces pass=0, fail_code=31'h7FFFFFFF, state DRAIN; when undefined no watchdog logic exists and RUN persists indefinitely.

Structure
REQ-029 Shared package holds register offsets, state encoding, and the timeout fail code constant.
REQ-030 The character FIFO is one sub-module, sim_ctrl_fifo (parameter DEPTH, width 8, count output).

Verification
REQ-031 Reset release, idle 10 cycles -> cycle_count=10, done=0, char_valid=0, req_ready=1.
REQ-032 PUTC 'A','B' with char_ready=1 -> char_data 0x41 then 0x42, one per cycle, FIFO empty afterwards.
REQ-033 char_ready=0, 5 PUTC writes, depth 4 -> 4 accepted, 5th stalls req_ready=0 until one pop, then accepted.
REQ-034 TOHOST=1 with 2 chars queued, char_ready=1 -> done rises after both pops, pass=1, cycle_count frozen.
REQ-035 TOHOST=7 -> done=1, pass=0, fail_code=3; later PUTC ignored; read STATUS -> 0x00000001, resp_valid one cycle later.
REQ-036 With SIM_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=50, no writes -> done at cycle 50 (+drain), fail_code=0x7FFFFFFF; rst low mid-DRAIN -> all reset values.
